// File: rtl/fetch_decode_buffer_pkg.sv
// Shared constants for the fetch/decode skid buffer.
//   XLEN          : PC and instruction word width
//   DEFAULT_DEPTH : default number of buffered fetch entries
//   NOP           : instruction word presented when the buffer is empty
package fetch_decode_buffer_pkg;
    localparam int XLEN          = 32;
    localparam int DEFAULT_DEPTH = 2;
    localparam logic [31:0] NOP  = 32'h0000_0000;
endpackage

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode instruction buffer: a small FIFO of (pc, instr) pairs
// sitting between the fetch stage and the decoder.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst          : synchronous active-low reset
//   in_valid     : fetch presents in_pc/in_instr
//   in_ready     : buffer has room (registered state only)
//   in_pc        : word address of the presented instruction
//   in_instr     : presented instruction word
//   flush        : redirect, drops all entries and the presented one
//   out_valid    : head entry available to decode
//   out_ready    : decode consumes the head entry
//   out_pc       : PC of head entry (0 when empty)
//   out_instr    : instruction of head entry (NOP when empty)
//   out_pc_next  : out_pc + 1, wraps at XLEN bits
//   count        : number of valid entries
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
#(
    parameter int DEPTH = fetch_decode_buffer_pkg::DEFAULT_DEPTH,
    parameter int XLEN  = fetch_decode_buffer_pkg::XLEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc_next,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if ((DEPTH < 2) || (DEPTH > 8) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fetch_decode_buffer: DEPTH must be a power of two in 2..8");
    end

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Handshake flags depend only on the registered count, so there is no
    // combinational path from out_ready/in_valid to in_ready.
    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; the empty-state masking below hides stale data.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    assign out_pc      = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr   = out_valid ? instr_mem[rd_ptr] : XLEN'(NOP);
    // Single incrementer; an empty buffer therefore reports 0 + 1 = 1.
    assign out_pc_next = out_pc + XLEN'(1);

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Scoreboard bench for fetch_decode_buffer. A queue-based reference model
// tracks buffered entries; entries the model says are consumed are pushed to
// a scoreboard that an independent monitor drains on each DUT handshake.
module tb_fetch_decode_buffer;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [XLEN-1:0]        in_pc = '0;
    logic [XLEN-1:0]        in_instr = '0;
    logic                   flush = 1'b0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [XLEN-1:0]        out_pc;
    logic [XLEN-1:0]        out_instr;
    logic [XLEN-1:0]        out_pc_next;
    logic [$clog2(DEPTH):0] count;

    ent_t  model_q[$];
    ent_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string phase    = "init";

    fetch_decode_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_pc_next(out_pc_next),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%s] got=%0h expected=%0h at %0t", name, phase, act, exp, $time);
    endtask

    // Compare registered-state outputs against the model's view of the buffer.
    task automatic check_state();
        logic [XLEN-1:0] epc, einstr, enext;
        epc    = (model_q.size() != 0) ? model_q[0].pc    : '0;
        einstr = (model_q.size() != 0) ? model_q[0].instr : '0;
        enext  = epc + 32'd1;
        chk("count",       64'(count),       64'(model_q.size()));
        chk("in_ready",    64'(in_ready),    64'(model_q.size() < DEPTH));
        chk("out_valid",   64'(out_valid),   64'(model_q.size() != 0));
        chk("out_pc",      64'(out_pc),      64'(epc));
        chk("out_instr",   64'(out_instr),   64'(einstr));
        chk("out_pc_next", 64'(out_pc_next), 64'(enext));
    endtask

    // One clock of stimulus: check the state left by the previous edge, drive
    // new inputs, and advance the model to what the next edge must produce.
    task automatic step(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] ins,
                        input logic rdy, input logic fl, input logic r);
        bit do_push, do_pop;
        ent_t e;
        @(posedge clk);
        #2;
        check_state();
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
        if (!r || fl) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() != 0) && rdy;
            do_push = (model_q.size() < DEPTH) && v;
            if (do_pop) exp_q.push_back(model_q.pop_front());
            if (do_push) begin
                e.pc = pc;
                e.instr = ins;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, '0, '0, rdy, 1'b0, 1'b1);
    endtask

    // Monitor: whenever the DUT completes a consume handshake, the head it
    // presents must be the next entry the model expects to leave.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst && !flush && out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_unexpected [%s] got pc=%0h expected no pop at %0t", phase, out_pc, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (out_pc === e.pc && out_instr === e.instr && out_pc_next === e.pc + 32'd1)
                        n_pass++;
                    else
                        $display("FAIL pop_order [%s] got pc=%0h instr=%0h next=%0h expected pc=%0h instr=%0h at %0t",
                                 phase, out_pc, out_instr, out_pc_next, e.pc, e.instr, $time);
                end
            end
        end
    end

    initial begin
        logic [XLEN-1:0] rpc;
        phase = "reset";
        step(1'b1, 32'd3, 32'h33, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        phase = "single_push";
        step(1'b1, 32'd5, 32'hA, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        phase = "fill_then_drain";
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'd0, 32'h100, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd1, 32'h101, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd2, 32'h102, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        phase = "push_pop_count1";
        step(1'b1, 32'd7, 32'h77, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd8, 32'h88, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        phase = "flush_full";
        step(1'b1, 32'd10, 32'hAA, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd11, 32'hBB, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd9, 32'h99, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);

        phase = "pc_wrap";
        step(1'b1, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        phase = "reset_midstream";
        step(1'b1, 32'd20, 32'h20, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd21, 32'h21, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'd22, 32'h22, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            step(1'($urandom_range(0, 3) != 0), rpc, $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 63) != 0));
        end

        phase = "drain";
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
